// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared state encoding and word-geometry constants for the boot loader
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD   = 4;
  localparam int WORD_BYTES_SHIFT = 2;

endpackage

// File: rtl/imem_boot_loader_byte_assembler.sv
// rtl/imem_boot_loader_byte_assembler.sv - 8-to-32 little-endian byte assembler, reused for header, data and checksum
module imem_boot_loader_byte_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic [7:0]  data_byte,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt;
  logic [23:0] low_bytes;

  // Bytes enter at the top and shift down, so after three bytes the
  // oldest one sits in [7:0] and the fourth completes the word directly.
  always_ff @(posedge clk) begin
    if (clear) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
    end else if (accept) begin
      byte_cnt  <= byte_cnt + 2'd1;
      low_bytes <= {data_byte, low_bytes[23:8]};
    end
  end

  assign word       = {data_byte, low_bytes};
  assign word_valid = accept && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a checksummed program image into instruction memory and releases CPU reset
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int          n         = 32,
  parameter int          MAX_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             imem_we,
  output logic [n-1:0]     imem_addr,
  output logic [n-1:0]     imem_wdata,
  output logic             cpu_rst,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] words_loaded
);

  state_t           state, state_next;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] word_idx_inc;
  logic [n-1:0]     run_xor;

  logic             accept;
  logic             asm_clear;
  logic [31:0]      asm_word;
  logic             asm_word_valid;

  assign in_ready = !rst && (state == HDR || state == LOAD || state == CHECK);
  assign accept   = in_valid && in_ready;

  // Any state change starts a fresh word, so a stale partial word can
  // never bleed from one phase into the next.
  assign asm_clear = rst || (state_next != state);

  imem_boot_loader_byte_assembler u_byte_assembler (
    .clk        (CLK),
    .clear      (asm_clear),
    .data_byte  (in_data),
    .accept     (accept),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  assign word_idx_inc = word_idx + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (asm_word_valid) begin
          if (asm_word > 32'(MAX_WORDS))
            state_next = ERR;
          else if (asm_word == 32'd0)
            state_next = CHECK;
          else
            state_next = LOAD;
        end
      end
      LOAD: begin
        if (asm_word_valid)
          state_next = WRITE;
      end
      WRITE: begin
        state_next = (word_idx_inc == n_words) ? CHECK : LOAD;
      end
      CHECK: begin
        if (asm_word_valid)
          state_next = (asm_word == run_xor) ? DONE : ERR;
      end
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= HDR;
      n_words    <= '0;
      word_idx   <= '0;
      run_xor    <= '0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
    end else begin
      state <= state_next;
      // The header has already been range-checked, so the low CNT_W bits hold N exactly.
      if (state == HDR && asm_word_valid)
        n_words <= asm_word[CNT_W-1:0];
      if (state == LOAD && asm_word_valid) begin
        imem_wdata <= asm_word;
        imem_addr  <= BASE_ADDR + (n'(word_idx) << WORD_BYTES_SHIFT);
      end
      if (state == WRITE) begin
        word_idx <= word_idx_inc;
        run_xor  <= run_xor ^ imem_wdata;
      end
    end
  end

  assign imem_we      = (state == WRITE);
  assign cpu_rst      = (state != DONE);
  assign load_done    = (state == DONE);
  assign load_err     = (state == ERR);
  assign words_loaded = word_idx;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader with randomized images
module tb_imem_boot_loader;

  localparam int          MAXW = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int tests  = 0;
  int failed = 0;
  int gap_mode = 0;

  logic [63:0] exp_q[$];
  logic [31:0] img[$];

  imem_boot_loader #(
    .n(32), .MAX_WORDS(MAXW), .BASE_ADDR(BASE), .CNT_W(16)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT issues must match the head of the expected queue.
  always @(negedge CLK) begin
    if (rst === 1'b0 && imem_we === 1'b1) begin
      check("in_ready_low_in_write", {63'd0, in_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", {32'd0, imem_addr}, {32'd0, e[63:32]});
        check("write_data", {32'd0, imem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    int t;
    g = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
    in_valid = 1'b0;
    repeat (g) @(posedge CLK);
    #1;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        tests++;
        failed++;
        $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles expected 1", t);
        break;
      end
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic do_reset();
    #1;
    rst      = 1'b1;
    in_valid = $urandom_range(0, 1);
    in_data  = $urandom_range(0, 255);
    @(negedge CLK);
    check("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    @(posedge CLK);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("rst_cpu_rst",   {63'd0, cpu_rst}, 64'd1);
    check("rst_load_done", {63'd0, load_done}, 64'd0);
    check("rst_load_err",  {63'd0, load_err}, 64'd0);
    check("rst_words",     {48'd0, words_loaded}, 64'd0);
    check("rst_we",        {63'd0, imem_we}, 64'd0);
    check("rst_addr",      {32'd0, imem_addr}, {32'd0, BASE});
    check("rst_wdata",     {32'd0, imem_wdata}, 64'd0);
  endtask

  // Reference model: an image is good only if N fits and the checksum equals
  // the XOR of the N data words; all N words are written either way.
  task automatic run_image(input logic [31:0] hdr, input logic [31:0] chk);
    logic        oversize;
    logic        exp_done;
    logic [31:0] x;
    int          exp_cnt;
    oversize = (hdr > 32'(MAXW));
    x = 32'd0;
    if (!oversize)
      for (int i = 0; i < int'(hdr); i++) begin
        x ^= img[i];
        exp_q.push_back({BASE + 32'(4 * i), img[i]});
      end
    exp_done = !oversize && (chk == x);
    exp_cnt  = oversize ? 0 : int'(hdr);

    send_word(hdr);
    if (!oversize) begin
      for (int i = 0; i < int'(hdr); i++) send_word(img[i]);
      send_word(chk);
    end
    check("done_next_cycle", {63'd0, load_done}, {63'd0, exp_done});
    check("err_next_cycle",  {63'd0, load_err}, {63'd0, !exp_done});
    check("cpu_rst_next",    {63'd0, cpu_rst}, {63'd0, !exp_done});
    in_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    in_valid = 1'b0;
    check("ready_after_end", {63'd0, in_ready}, 64'd0);
    check("sticky_done",     {63'd0, load_done}, {63'd0, exp_done});
    check("sticky_err",      {63'd0, load_err}, {63'd0, !exp_done});
    check("words_loaded",    {48'd0, words_loaded}, 64'(exp_cnt));
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] img_xor(input int cnt);
    logic [31:0] x;
    x = 32'd0;
    for (int i = 0; i < cnt; i++) x ^= img[i];
    return x;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge CLK);
    do_reset();

    // Normal two-word load
    img = {32'h2008_0005, 32'h2009_0007};
    run_image(32'd2, 32'h0001_0002);

    // Byte order with 3-cycle gaps between bytes
    do_reset();
    gap_mode = 3;
    img = {32'h1234_5678};
    run_image(32'd1, 32'h1234_5678);
    gap_mode = 0;

    // Bad checksum: the word is still written
    do_reset();
    img = {32'hDEAD_BEEF};
    run_image(32'd1, 32'd0);

    // Oversize header and zero-length image
    do_reset();
    run_image(32'd65, 32'd0);
    do_reset();
    run_image(32'd0, 32'd0);

    // Reset partway through the first data word
    do_reset();
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("partial_not_done", {63'd0, load_done}, 64'd0);
    do_reset();
    img = {32'hCAFE_0001};
    run_image(32'd1, 32'hCAFE_0001);

    // Largest accepted image
    do_reset();
    gap_mode = 0;
    img.delete();
    for (int i = 0; i < MAXW; i++) img.push_back($urandom);
    run_image(32'(MAXW), img_xor(MAXW));

    // Randomized images
    gap_mode = -1;
    for (int r = 0; r < 14; r++) begin
      int          sel;
      int          nw;
      logic [31:0] hdr;
      logic [31:0] chk;
      do_reset();
      sel = $urandom_range(0, 9);
      img.delete();
      if (sel == 0) begin
        hdr = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'(65 + $urandom_range(0, 1000));
        nw  = 0;
      end else begin
        nw  = (sel == 1) ? 0 : int'($urandom_range(1, 6));
        hdr = 32'(nw);
      end
      for (int i = 0; i < nw; i++) img.push_back($urandom);
      chk = img_xor(nw);
      if ($urandom_range(0, 3) == 0) chk ^= (32'd1 << $urandom_range(0, 31));
      run_image(hdr, chk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
